// File: rtl/esn_pe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : esn_pe_sequencer
//  Brief    : Initiator for one 8-in/4-out processing element. Streams a
//             synapse set into the PE weight bus, latches the input-neuron
//             vector, runs the PE compute window and captures its result.
//  Revision : 1.0  initial release
// ============================================================================
module esn_pe_sequencer #(
    parameter int WORD_LEN = 16,
    parameter int NEU_IN   = 8,
    parameter int NEU_OUT  = 4,
    parameter int PE_LAT   = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                reuse_w,
    input  logic [WORD_LEN*NEU_IN-1:0]          u_in,
    input  logic                                w_valid,
    input  logic [WORD_LEN-1:0]                 w_data,
    output logic                                w_ready,
    output logic [WORD_LEN*NEU_IN-1:0]          pe_data,
    output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  pe_weight,
    output logic                                pe_ce,
    input  logic [WORD_LEN*NEU_OUT-1:0]         pe_q,
    output logic [WORD_LEN*NEU_OUT-1:0]         y_out,
    output logic                                y_valid,
    output logic                                busy
);

    localparam int N_W    = NEU_IN * NEU_OUT;
    localparam int WCNT_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int LCNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        EXEC    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [WCNT_W-1:0]   wcnt;
    logic [LCNT_W-1:0]   lcnt;
    logic                w_accept;
    logic                w_last;
    logic                lat_last;

    assign w_accept = (state == LOAD) && w_valid;
    assign w_last   = (wcnt == WCNT_W'(N_W - 1));
    assign lat_last = (lcnt == LCNT_W'(PE_LAT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived handshake / PE control outputs.
    always_comb begin
        state_nx = state;
        w_ready  = 1'b0;
        pe_ce    = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = reuse_w ? EXEC : LOAD;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && w_last) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                pe_ce = 1'b1;
                if (lat_last) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                // One extra enable so the PE output register takes the result.
                pe_ce    = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: vector latch, weight slice writes, counters and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_data   <= '0;
            pe_weight <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            wcnt      <= '0;
            lcnt      <= '0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pe_data <= u_in;
                        lcnt    <= '0;
                        if (!reuse_w) begin
                            wcnt <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        // Word k lands in slice k; slices 0..NEU_IN-1 feed output 0.
                        for (int k = 0; k < N_W; k++) begin
                            if (wcnt == WCNT_W'(k)) begin
                                pe_weight[k*WORD_LEN +: WORD_LEN] <= w_data;
                            end
                        end
                        wcnt <= w_last ? '0 : wcnt + 1'b1;
                    end
                end
                EXEC: begin
                    lcnt <= lat_last ? '0 : lcnt + 1'b1;
                end
                CAPTURE: begin
                    y_out   <= pe_q;
                    y_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esn_pe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_esn_pe_sequencer
//  Brief    : Table-driven self-checking bench for esn_pe_sequencer with a
//             behavioural two-stage PE model behind it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_esn_pe_sequencer;

    localparam int WL = 16;
    localparam int NI = 8;
    localparam int NO = 4;
    localparam int PL = 2;
    localparam int NW = NI * NO;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 reuse_w = 1'b0;
    logic [WL*NI-1:0]     u_in = '0;
    logic                 w_valid = 1'b0;
    logic [WL-1:0]        w_data = '0;
    logic                 w_ready;
    logic [WL*NI-1:0]     pe_data;
    logic [WL*NI*NO-1:0]  pe_weight;
    logic                 pe_ce;
    logic [WL*NO-1:0]     pe_q;
    logic [WL*NO-1:0]     pe_s1;
    logic [WL*NO-1:0]     y_out;
    logic                 y_valid;
    logic                 busy;

    esn_pe_sequencer #(.WORD_LEN(WL), .NEU_IN(NI), .NEU_OUT(NO), .PE_LAT(PL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .reuse_w   (reuse_w),
        .u_in      (u_in),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .pe_data   (pe_data),
        .pe_weight (pe_weight),
        .pe_ce     (pe_ce),
        .pe_q      (pe_q),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Fixed-point matrix-vector product: Q3.12 x Q0.15 accumulated, bits [30:15].
    function automatic logic [WL*NO-1:0] pe_func(input logic [WL*NI-1:0] d,
                                                 input logic [WL*NI*NO-1:0] w);
        logic [WL*NO-1:0]     r;
        longint               acc;
        logic signed [WL-1:0] a;
        logic signed [WL-1:0] b;
        r = '0;
        for (int j = 0; j < NO; j++) begin
            acc = 0;
            for (int i = 0; i < NI; i++) begin
                a = d[i*WL +: WL];
                b = w[(j*NI+i)*WL +: WL];
                acc += longint'(a) * longint'(b);
            end
            r[j*WL +: WL] = acc[30:15];
        end
        return r;
    endfunction

    // Behavioural PE: two registered stages, both enabled by ce.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_s1 <= '0;
            pe_q  <= '0;
        end else if (pe_ce) begin
            pe_s1 <= pe_func(pe_data, pe_weight);
            pe_q  <= pe_s1;
        end
    end

    typedef struct {
        logic [WL*NI-1:0] u;
        bit               reuse;
        logic [WL-1:0]    w_base;
        int               gaps;
        bit               poke;
    } pass_t;

    int                   n_cmp = 0;
    int                   n_bad = 0;
    logic [WL*NI*NO-1:0]  exp_w = '0;
    logic [WL*NO-1:0]     last_y = '0;
    pass_t                tbl[5];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pass from start to y_valid; abort_after>0 returns after that many words.
    task automatic run_pass(input pass_t p, input bit chained, input int abort_after, input bit stay);
        int               cyc;
        int               k;
        int               gaps_left;
        int               ce_cnt;
        int               rdy_cnt;
        int               yv_cyc;
        int               exp_lat;
        bit               held_ok;
        bit               data_ok;
        logic [WL*NO-1:0] exp_y;
        if (!chained) @(negedge clk);
        start   = 1'b1;
        reuse_w = p.reuse;
        u_in    = p.u;
        @(negedge clk);
        start   = 1'b0;
        u_in    = ~p.u;
        reuse_w = ~p.reuse;
        cyc = 1; k = 0; gaps_left = p.gaps; ce_cnt = 0; rdy_cnt = 0;
        yv_cyc = -1; held_ok = 1'b1; data_ok = 1'b1;
        while (cyc < 200) begin
            start = 1'b0;
            if (y_valid) begin
                yv_cyc = cyc;
                break;
            end
            if (y_out !== last_y) held_ok = 1'b0;
            if (pe_data !== p.u) data_ok = 1'b0;
            if (pe_ce) ce_cnt++;
            if (w_ready) rdy_cnt++;
            if (abort_after > 0 && k == abort_after) begin
                w_valid = 1'b0;
                return;
            end
            w_valid = 1'b0;
            if (w_ready) begin
                if (gaps_left > 0 && ($urandom_range(0, 3) == 0 || (NW - k) <= gaps_left)) begin
                    gaps_left--;
                end else begin
                    w_valid = 1'b1;
                    w_data  = 16'(int'(p.w_base) + k);
                    exp_w[k*WL +: WL] = w_data;
                    k++;
                end
            end else begin
                w_valid = 1'($urandom_range(0, 1));
                w_data  = 16'($urandom);
            end
            if (p.poke && (cyc == 3 || pe_ce)) begin
                start   = 1'b1;
                reuse_w = 1'b1;
                u_in    = {4{32'($urandom)}};
            end
            @(negedge clk);
            cyc++;
        end
        w_valid = 1'b0;
        exp_lat = p.reuse ? PL + 2 : NW + p.gaps + PL + 2;
        exp_y   = pe_func(p.u, exp_w);
        check("latency", 512'(yv_cyc), 512'(exp_lat));
        check("y_out", 512'(y_out), 512'(exp_y));
        check("pe_weight", 512'(pe_weight), 512'(exp_w));
        check("pe_data", 512'(pe_data), 512'(p.u));
        check("pe_data_stable", 512'(data_ok), 512'(1));
        check("y_out_held", 512'(held_ok), 512'(1));
        check("ce_cycles", 512'(ce_cnt), 512'(PL + 1));
        check("ready_cycles", 512'(rdy_cnt), 512'(p.reuse ? 0 : NW + p.gaps));
        last_y = exp_y;
        if (!stay) begin
            @(negedge clk);
            check("y_valid_one_pulse", 512'(y_valid), 512'(0));
            check("idle_after", 512'(busy), 512'(0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_t b2b_a;
        pass_t b2b_b;
        pass_t part;
        pass_t zero_w;

        // Stimulus table.
        for (int i = 0; i < NI; i++) begin
            tbl[0].u[i*WL +: WL] = 16'((i + 1) * 256);
            tbl[2].u[i*WL +: WL] = 16'h7FFF;
            tbl[3].u[i*WL +: WL] = 16'(i * 16'h1111) ^ 16'h8000;
            tbl[4].u[i*WL +: WL] = 16'(16'hFF00 + i);
        end
        tbl[0].reuse = 1'b0; tbl[0].w_base = 16'hA000; tbl[0].gaps = 5; tbl[0].poke = 1'b0;
        tbl[1].u = tbl[0].u;
        tbl[1].reuse = 1'b0; tbl[1].w_base = 16'h0000; tbl[1].gaps = 0; tbl[1].poke = 1'b0;
        tbl[2].reuse = 1'b1; tbl[2].w_base = 16'h0000; tbl[2].gaps = 0; tbl[2].poke = 1'b0;
        tbl[3].reuse = 1'b0; tbl[3].w_base = 16'h0040; tbl[3].gaps = 2; tbl[3].poke = 1'b1;
        tbl[4].reuse = 1'b1; tbl[4].w_base = 16'h0000; tbl[4].gaps = 0; tbl[4].poke = 1'b1;

        // Reset state.
        #12;
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_outputs", 512'({pe_ce, y_valid, w_ready}), 512'(0));
        check("rst_y_out", 512'(y_out), 512'(0));
        check("rst_pe_weight", 512'(pe_weight), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven passes: stalled load, full load, reuse, ignored starts.
        for (int t = 0; t < 5; t++) begin
            run_pass(tbl[t], 1'b0, 0, 1'b0);
            if (t == 1) begin
                check("slice3", 512'(pe_weight[3*WL +: WL]), 512'(3));
                check("data_word3", 512'(pe_data[3*WL +: WL]), 512'(16'h0400));
            end
        end

        // Back-to-back: second start in the y_valid cycle of the first pass.
        b2b_a = tbl[2];
        b2b_b = tbl[4];
        b2b_b.poke = 1'b0;
        run_pass(b2b_a, 1'b0, 0, 1'b1);
        run_pass(b2b_b, 1'b1, 0, 1'b0);

        // Asynchronous reset in the middle of a load.
        part = tbl[1];
        part.w_base = 16'h1234;
        run_pass(part, 1'b0, 10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", 512'(busy), 512'(0));
        check("async_ctrl", 512'({pe_ce, y_valid, w_ready}), 512'(0));
        check("async_pe_data", 512'(pe_data), 512'(0));
        check("async_pe_weight", 512'(pe_weight), 512'(0));
        check("async_y_out", 512'(y_out), 512'(0));
        exp_w  = '0;
        last_y = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reuse after reset runs on the cleared weights.
        zero_w = tbl[2];
        run_pass(zero_w, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esn_pe_sequencer.md
Name: esn_pe_sequencer

Overview:
- Initiator side of the 8-in/4-out 16-bit processing element interface.
- Accepts a streamed synapse set and writes it into the PE's flat WEIGHT bus.
- Latches the input-neuron vector, drives the PE's ce for the compute window, then captures and presents the PE's Q output with a valid pulse.
- Sits between the reservoir memory/controller and one PE instance.

Parameters:
- WORD_LEN, 16, bits per neuron/synapse word (Q0.15 synapse, Q3.12 input neuron, Q0.15 output).
- NEU_IN, 8, input neurons per PE.
- NEU_OUT, 4, output neurons per PE.
- PE_LAT, 2, cycles of ce-high needed before PE Q reflects the new DATA/WEIGHT (tf_tanh register plus output register); minimum 1.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one matrix-vector pass; sampled only in IDLE.
- reuse_w  in  1  sampled with start; 1 = skip weight load and keep the current weight register.
- u_in  in  WORD_LEN*NEU_IN  input-neuron vector, latched on accepted start.
- w_valid  in  1  weight stream word valid.
- w_data  in  WORD_LEN  weight stream word.
- w_ready  out  1  weight stream ready; high only in LOAD.
- pe_data  out  WORD_LEN*NEU_IN  to PE DATA; registered copy of u_in.
- pe_weight  out  WORD_LEN*NEU_IN*NEU_OUT  to PE WEIGHT; registered.
- pe_ce  out  1  to PE ce.
- pe_q  in  WORD_LEN*NEU_OUT  from PE Q.
- y_out  out  WORD_LEN*NEU_OUT  captured PE result.
- y_valid  out  1  one-cycle pulse when y_out updates.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) clears all state and outputs:
  - state = IDLE.
  - pe_data, pe_weight, y_out = 0.
  - pe_ce, y_valid, w_ready, busy = 0.
  - weight counter = 0, latency counter = 0.
- Reset asserted mid-LOAD or mid-EXEC aborts the pass. No y_valid is produced. The weight register must be reloaded, because reuse_w after reset uses the zeroed weights.
- The FSM has four states: IDLE, LOAD, EXEC, CAPTURE.
- IDLE:
  - On start=1, latch u_in into pe_data.
  - If reuse_w=1, go to EXEC; otherwise clear the weight counter and go to LOAD.
  - start=0 keeps the FSM in IDLE.
- LOAD:
  - w_ready=1.
  - A word is accepted on any cycle with w_valid=1 and w_ready=1.
  - Word k (k = 0 .. NEU_IN*NEU_OUT-1, in arrival order) is written to pe_weight[(k+1)*WORD_LEN-1 -: WORD_LEN]. Words 0..7 therefore feed output neuron 0, words 8..15 feed output neuron 1, and so on.
  - The counter width is clog2(NEU_IN*NEU_OUT).
  - On acceptance of the last word (k=31 at defaults), go to EXEC; w_ready deasserts the next cycle.
  - w_valid=0 stalls indefinitely with no timeout.
  - Words presented outside LOAD are ignored (w_ready=0).
- EXEC:
  - pe_ce=1 for exactly PE_LAT consecutive cycles, counted by the latency counter, then go to CAPTURE.
  - pe_data and pe_weight are stable throughout EXEC.
- CAPTURE:
  - pe_ce=1 for this one cycle, so the PE output register takes the final result.
  - Next cycle: y_out <= pe_q, y_valid=1 for one cycle, pe_ce=0, state returns to IDLE.
  - With pe_ce=0 the PE holds its Q.
  - Total start-to-y_valid latency:
    - reuse_w=1: PE_LAT+2 cycles.
    - reuse_w=0 with w_valid held high: 32+PE_LAT+2 cycles.
- y_out holds its value until the next capture; it is never cleared except by reset.
- start while busy=1 is ignored; no queueing.
- start is accepted in the same cycle y_valid is high (FSM already IDLE), allowing back-to-back passes.
- u_in changes after acceptance have no effect on pe_data until the next accepted start.
- No arithmetic is performed here; all words pass bit-exact.

Test Plan:
- Reset values: assert rst_n=0 mid-LOAD after 10 words -> all outputs 0 immediately (asynchronous), state IDLE, busy=0. A following reuse_w=1 pass drives pe_weight=0.
- Full load: start, reuse_w=0, u_in word i = 16'h0100*(i+1), stream w_data=k for k=0..31 with w_valid held high -> pe_weight slice k == k, pe_data word 3 == 16'h0400. pe_ce high exactly PE_LAT+1 cycles. y_valid pulses 32+PE_LAT+2 cycles after start, with y_out == the bench-model PE Q.
- Stalled stream: same as full load but with w_valid low for 5 random gaps -> only valid words written in order, no skipped or duplicate slice, w_ready=0 after word 31.
- Weight reuse: after the full load, start with reuse_w=1 and u_in=all 16'h7FFF -> pe_weight unchanged, y_valid at PE_LAT+2 cycles, w_ready never high.
- Ignored start: pulse start during LOAD and EXEC -> no restart, pe_data unchanged, exactly one y_valid.
- Back-to-back: assert start in the y_valid cycle with reuse_w=1 -> second pass accepted that cycle, second y_valid exactly PE_LAT+2 cycles later, first y_out held until then.
